dds_multich_ctrl: RTL and testbench
===================================

# dds_multich_ctrl

Parametrised multi-channel DDS phase/amplitude controller. It generates a programmable sample-rate tick and runs NUM_CH phase accumulators with per-channel frequency word, phase offset and amplitude. Configuration words are double-buffered and committed atomically on a sample tick. The phase addresses and amplitudes it outputs drive the sine LUT / DAC scaling stage.

## Interface
Parameters:
- NUM_CH, 2, number of channels (≥1)
- ACC_WIDTH, 28, phase accumulator and frequency word width
- ADDR_WIDTH, 16, LUT address width per channel (≤ ACC_WIDTH)
- DAC_WIDTH, 12, amplitude word width
- DIV_WIDTH, 16, sample divider width
- CH_W, max($clog2(NUM_CH),1), channel index width (localparam)

Ports:
- clk  in  1  system clock
- rst  in  1  one clock; reset is synchronous and active-high
- div_ratio  in  DIV_WIDTH  tick period minus one
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accept
- cfg_ch  in  CH_W  target channel
- cfg_sel  in  2  0=freq, 1=phase offset, 2=amplitude, 3=commit
- cfg_data  in  ACC_WIDTH  write data; amplitude uses [DAC_WIDTH-1:0]
- tick  out  1  sample-enable pulse
- phase_addr  out  NUM_CH*ADDR_WIDTH  channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
- ampl  out  NUM_CH*DAC_WIDTH  channel c at [c*DAC_WIDTH +: DAC_WIDTH]
- out_valid  out  1  phase_addr/ampl updated this cycle

## Operation
- Divider: cnt counts up by 1 each cycle. When cnt ≥ div_ratio, tick=1 (combinational) and cnt wraps to 0. div_ratio=0 gives a tick every cycle. If div_ratio is lowered below cnt, the tick fires on the next cycle. tick is forced 0 while rst=1.
- Config write: a transfer occurs when cfg_valid && cfg_ready.
  - sel 0/1/2 write the shadow freq/poff/ampl of cfg_ch.
  - If cfg_ch ≥ NUM_CH, the write is accepted and dropped.
- Commit: sel 3 ignores cfg_ch and sets pending. cfg_ready=!pending.
  - On the next tick after acceptance, all shadow words copy to the active registers simultaneously and pending clears.
  - A commit accepted in the same cycle as a tick waits for the following tick.
- Accumulator: on each tick, acc[c] ← acc[c] + freq_active[c], mod 2^ACC_WIDTH; wrap is silent. On a commit tick the increment uses the pre-commit freq_active.
- Output stage: in the cycle after a tick, register phase_addr[c] ← (acc[c] + poff_active[c])[ACC_WIDTH-1 -: ADDR_WIDTH] and ampl[c] ← ampl_active[c]. out_valid pulses for one cycle.
- Reset clears cnt, pending, acc, and all shadow and active registers.

## Timing
- Reset values: phase_addr=0, ampl=0, out_valid=0, tick=0, cfg_ready=0 while rst=1. cfg_ready=1 from the first cycle after rst falls.
- Tick in cycle T → acc updated at the end of T → out_valid=1 in cycle T+2 with new values. Latency is 2 cycles.
- Commit accepted in cycle A, first tick after A in cycle T:
  - active registers valid from T+1
  - cfg_ready=1 again in T+1
  - new poff/ampl visible at outputs in T+2
  - new freq affects the acc step at the tick after T
- Reset mid-operation: all state returns to reset values at the next edge. A pending commit is discarded.
- Back-to-back writes: one write per cycle while cfg_ready=1.

## Configuration
- DDS_PHASE_CLEAR_EN defined: cfg_data[0]=1 on a commit write requests phase clear. On the commit tick all acc ← 0 instead of incrementing, so the channels are phase-aligned.
- Not defined: cfg_data on commit is ignored and the accumulators free-run.

## Test plan
- Reset: hold rst 3 cycles → all outputs 0 and cfg_ready=0 during reset; cfg_ready=1 on the first cycle after rst falls; no tick during reset.
- Divider: div_ratio=3 → tick every 4th cycle. Switch to 0 → tick every cycle. Switch from 9 to 2 with cnt=5 → tick the next cycle, then every 3 cycles.
- Frequency: ch0 freq=2^24, ch1 freq=2^25, commit, div_ratio=0 → per-tick phase_addr step is 0x1000 (ch0) and 0x2000 (ch1). ch0 wraps to 0x0000 after 16 steps. out_valid appears 2 cycles after each tick.
- Commit backpressure: div_ratio=9, commit accepted → cfg_ready=0 until the cycle after the next tick. A freq write held with cfg_valid=1 stalls, then is accepted. Old outputs persist until T+2.
- Phase offset/amplitude: both channels freq=2^24, ch1 poff=2^27, ampl ch0=0xFFF, ch1=0x800 → ch1 addr = ch0 addr + 0x8000 every sample; ampl outputs 0xFFF and 0x800. A write to cfg_ch=NUM_CH has no effect.
- DDS_PHASE_CLEAR_EN: commit with cfg_data=1 → first out_valid after the commit tick shows phase_addr = poff-derived value (0 for zero offset) on all channels. Without the macro, the accumulators continue unchanged.

Source files
------------

// File: rtl/dds_multich_ctrl.sv
// dds_multich_ctrl: multi-channel DDS phase/amplitude controller.
// A programmable divider produces the sample tick. Each channel keeps
// double-buffered freq/poff/ampl words that are committed atomically on a tick.
// Optional build macro DDS_PHASE_CLEAR_EN: a commit with cfg_data[0]=1 zeroes
// every accumulator on the commit tick so all channels restart phase-aligned.

module dds_ch #(
    parameter int ACC_WIDTH  = 28,
    parameter int ADDR_WIDTH = 16,
    parameter int DAC_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_freq,
    input  logic                  wr_poff,
    input  logic                  wr_ampl,
    input  logic                  commit,
    input  logic                  phase_clr,
    input  logic                  step,
    input  logic                  load,
    input  logic [ACC_WIDTH-1:0]  cfg_data,
    output logic [ADDR_WIDTH-1:0] phase_addr,
    output logic [DAC_WIDTH-1:0]  ampl
);
    logic [ACC_WIDTH-1:0] sh_freq, sh_poff, act_freq, act_poff, acc, phase;
    logic [DAC_WIDTH-1:0] sh_ampl, act_ampl;

    assign phase = acc + act_poff;

    // Shadow words take host writes at any time while the top accepts them
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_freq <= '0;
            sh_poff <= '0;
            sh_ampl <= '0;
        end else begin
            if (wr_freq) sh_freq <= cfg_data;
            if (wr_poff) sh_poff <= cfg_data;
            if (wr_ampl) sh_ampl <= cfg_data[DAC_WIDTH-1:0];
        end
    end

    // Active words change only on a commit tick, all together
    always_ff @(posedge clk) begin
        if (rst) begin
            act_freq <= '0;
            act_poff <= '0;
            act_ampl <= '0;
        end else if (commit) begin
            act_freq <= sh_freq;
            act_poff <= sh_poff;
            act_ampl <= sh_ampl;
        end
    end

    // Accumulator steps with the pre-commit freq; wrap is silent
    always_ff @(posedge clk) begin
        if (rst)       acc <= '0;
        else if (step) acc <= phase_clr ? '0 : acc + act_freq;
    end

    // Output register loads one cycle after the tick, from the updated acc
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_addr <= '0;
            ampl       <= '0;
        end else if (load) begin
            phase_addr <= ADDR_WIDTH'(phase >> (ACC_WIDTH - ADDR_WIDTH));
            ampl       <= act_ampl;
        end
    end
endmodule

module dds_multich_ctrl #(
    parameter int NUM_CH     = 2,
    parameter int ACC_WIDTH  = 28,
    parameter int ADDR_WIDTH = 16,
    parameter int DAC_WIDTH  = 12,
    parameter int DIV_WIDTH  = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DIV_WIDTH-1:0]         div_ratio,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [1:0]                   cfg_sel,
    input  logic [ACC_WIDTH-1:0]         cfg_data,
    output logic                         tick,
    output logic [NUM_CH*ADDR_WIDTH-1:0] phase_addr,
    output logic [NUM_CH*DAC_WIDTH-1:0]  ampl,
    output logic                         out_valid
);
    localparam int STAGES = 2;

    logic [DIV_WIDTH-1:0] cnt;
    logic                 pending;
    logic                 xfer;
    logic                 commit_now;
    logic                 do_clear;
    logic [STAGES:0]      vld_pipe;

    assign tick       = !rst && (cnt >= div_ratio);
    assign cfg_ready  = !rst && !pending;
    assign xfer       = cfg_valid && cfg_ready;
    assign commit_now = tick && pending;
    assign vld_pipe[0] = tick;
    assign out_valid  = vld_pipe[STAGES];

    // Sample divider: a lowered div_ratio below cnt fires on the next cycle
    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // Commit request waits for the first tick after acceptance
    always_ff @(posedge clk) begin
        if (rst)                        pending <= 1'b0;
        else if (xfer && cfg_sel == 2'd3) pending <= 1'b1;
        else if (commit_now)            pending <= 1'b0;
    end

`ifdef DDS_PHASE_CLEAR_EN
    logic clr_pend;

    // Phase-clear request travels with the pending commit
    always_ff @(posedge clk) begin
        if (rst)                          clr_pend <= 1'b0;
        else if (xfer && cfg_sel == 2'd3) clr_pend <= cfg_data[0];
    end

    assign do_clear = commit_now && clr_pend;
`else
    assign do_clear = 1'b0;
`endif

    // Tick -> load -> out_valid
    always_ff @(posedge clk) begin
        if (rst) vld_pipe[STAGES:1] <= '0;
        else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit;
        // Out-of-range channel indices match no lane, so the write drops
        assign hit = xfer && (cfg_ch == CH_W'(c));

        dds_ch #(
            .ACC_WIDTH (ACC_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .DAC_WIDTH (DAC_WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr_freq   (hit && cfg_sel == 2'd0),
            .wr_poff   (hit && cfg_sel == 2'd1),
            .wr_ampl   (hit && cfg_sel == 2'd2),
            .commit    (commit_now),
            .phase_clr (do_clear),
            .step      (tick),
            .load      (vld_pipe[1]),
            .cfg_data  (cfg_data),
            .phase_addr(phase_addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .ampl      (ampl[c*DAC_WIDTH +: DAC_WIDTH])
        );
    end
endmodule

// File: tb/tb_dds_multich_ctrl.sv
// Bench for dds_multich_ctrl: directed steps plus random traffic, checked
// every cycle against an arithmetic model of the sample/commit behaviour.
module tb_dds_multich_ctrl;
    localparam int NCH = 3, AW = 28, ADW = 16, DW = 12, DVW = 16, CW = 2;
    localparam longint MODV = 64'd1 << AW;
    localparam longint DIVV = 64'd1 << (AW - ADW);
    localparam longint AMOD = 64'd1 << DW;

    logic clk = 1'b0;
    logic rst;
    logic [DVW-1:0] div_ratio;
    logic cfg_valid, cfg_ready;
    logic [CW-1:0] cfg_ch;
    logic [1:0] cfg_sel;
    logic [AW-1:0] cfg_data;
    logic tick, out_valid;
    logic [NCH*ADW-1:0] phase_addr;
    logic [NCH*DW-1:0] ampl;

    dds_multich_ctrl #(.NUM_CH(NCH), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW),
                       .DAC_WIDTH(DW), .DIV_WIDTH(DVW)) dut (
        .clk(clk), .rst(rst), .div_ratio(div_ratio), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data), .tick(tick), .phase_addr(phase_addr),
        .ampl(ampl), .out_valid(out_valid));

    always #5 clk = ~clk;

    int errs = 0, checks = 0, ntick = 0;
    bit last_acc = 0;
    logic [ADW-1:0] q0[$], q1[$];

    // reference model state
    int  m_cnt = 0;
    bit  m_pend = 0, m_clr = 0, m_td = 0, e_ov = 0;
    longint m_acc[NCH], sh_f[NCH], sh_p[NCH], sh_a[NCH];
    longint ac_f[NCH], ac_p[NCH], ac_a[NCH], e_pa[NCH], e_am[NCH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pend = 0; m_clr = 0; m_td = 0; e_ov = 0;
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0; sh_f[c] = 0; sh_p[c] = 0; sh_a[c] = 0;
            ac_f[c] = 0; ac_p[c] = 0; ac_a[c] = 0; e_pa[c] = 0; e_am[c] = 0;
        end
    endtask

    // one clock: check comb outputs mid-cycle, advance model, check registers
    task automatic step();
        bit e_tick, e_rdy, clr_now;
        @(negedge clk);
        e_tick = !rst && (m_cnt >= int'(div_ratio));
        e_rdy  = !rst && !m_pend;
        chk("tick", 64'(tick), 64'(e_tick));
        chk("cfg_ready", 64'(cfg_ready), 64'(e_rdy));
        if (tick === 1'b1) ntick++;
        last_acc = cfg_valid && e_rdy;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            e_ov = m_td;
            if (m_td)
                for (int c = 0; c < NCH; c++) begin
                    e_pa[c] = ((m_acc[c] + ac_p[c]) % MODV) / DIVV;
                    e_am[c] = ac_a[c];
                end
            if (e_tick) begin
`ifdef DDS_PHASE_CLEAR_EN
                clr_now = m_pend && m_clr;
`else
                clr_now = 0;
`endif
                for (int c = 0; c < NCH; c++)
                    m_acc[c] = clr_now ? 0 : (m_acc[c] + ac_f[c]) % MODV;
                if (m_pend) begin
                    ac_f = sh_f; ac_p = sh_p; ac_a = sh_a; m_pend = 0;
                end
            end
            m_cnt = e_tick ? 0 : m_cnt + 1;
            if (last_acc) begin
                if (cfg_sel == 2'd3) begin
                    m_pend = 1; m_clr = cfg_data[0];
                end else if (int'(cfg_ch) < NCH) begin
                    case (cfg_sel)
                        2'd0: sh_f[int'(cfg_ch)] = longint'(cfg_data);
                        2'd1: sh_p[int'(cfg_ch)] = longint'(cfg_data);
                        default: sh_a[int'(cfg_ch)] = longint'(cfg_data) % AMOD;
                    endcase
                end
            end
            m_td = e_tick;
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("phase_addr[%0d]", c), 64'(phase_addr[c*ADW +: ADW]), 64'(e_pa[c]));
            chk($sformatf("ampl[%0d]", c), 64'(ampl[c*DW +: DW]), 64'(e_am[c]));
        end
        if (out_valid === 1'b1) begin
            q0.push_back(phase_addr[0 +: ADW]);
            q1.push_back(phase_addr[ADW +: ADW]);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int ch, input int sel, input logic [AW-1:0] d);
        cfg_valid = 1; cfg_ch = CW'(ch); cfg_sel = 2'(sel); cfg_data = d;
        for (int i = 0; i < 50; i++) begin
            step();
            if (last_acc) break;
        end
        chk("wr_accepted", 64'(last_acc), 64'd1);
        cfg_valid = 0;
    endtask

    task automatic wait_tick();
        ntick = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ntick != 0) break;
        end
        chk("wait_tick", 64'(ntick), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, stalls;
        logic [ADW-1:0] d, prev0;
        model_reset();
        rst = 1; div_ratio = 3; cfg_valid = 0; cfg_ch = 0; cfg_sel = 0; cfg_data = 0;

        // reset held 3 cycles: outputs zero, no tick, not ready
        ntick = 0;
        run(3);
        chk("rst_no_tick", 64'(ntick), 64'd0);
        rst = 0;
        run(1);
        chk("ready_after_rst", 64'(cfg_ready), 64'd1);

        // divider: 3 -> every 4th, 0 -> every cycle, 9 -> 2 with cnt=5
        ntick = 0; run(12);
        chk("div3_ticks", 64'(ntick), 64'd3);
        div_ratio = 0; ntick = 0; run(5);
        chk("div0_ticks", 64'(ntick), 64'd5);
        div_ratio = 9; wait_tick();
        run(5);
        chk("div9_quiet", 64'(ntick), 64'd1);
        div_ratio = 2; ntick = 0; step();
        chk("div_lower_immediate", 64'(ntick), 64'd1);
        run(2);
        chk("div2_gap", 64'(ntick), 64'd1);
        step();
        chk("div2_period", 64'(ntick), 64'd2);

        // frequency steps and 16-sample wrap
        wr(0, 0, 28'(1 << 24));
        wr(1, 0, 28'(1 << 25));
        wr(0, 3, 0);
        div_ratio = 0; q0.delete(); q1.delete();
        run(40);
        n = q0.size();
        chk("freq_samples", 64'(n >= 20), 64'd1);
        if (n >= 20) begin
            for (int k = 1; k <= 3; k++) begin
                d = q0[n-k] - q0[n-k-1];
                chk("ch0_step", 64'(d), 64'h1000);
                d = q1[n-k] - q1[n-k-1];
                chk("ch1_step", 64'(d), 64'h2000);
            end
            chk("ch0_wrap16", 64'(q0[n-1]), 64'(q0[n-17]));
        end

        // commit backpressure: write stalls until the cycle after the tick
        div_ratio = 9; wait_tick();
        wr(0, 3, 0);
        cfg_valid = 1; cfg_ch = 0; cfg_sel = 0; cfg_data = 28'(1 << 23);
        stalls = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (last_acc) break;
            stalls++;
        end
        cfg_valid = 0;
        chk("bp_stall_cycles", 64'(stalls), 64'd9);

        // phase offset / amplitude, plus out-of-range channel writes
        rst = 1; run(2); rst = 0;
        wr(0, 0, 28'(1 << 24));
        wr(1, 0, 28'(1 << 24));
        wr(1, 1, 28'(1 << 27));
        wr(0, 2, 28'h0FFF);
        wr(1, 2, 28'h0800);
        wr(3, 2, 28'h0123);
        wr(3, 0, 28'hFFFFFFF);
        wr(0, 3, 0);
        div_ratio = 0; q0.delete(); q1.delete();
        run(20);
        n = q0.size();
        chk("poff_samples", 64'(n >= 4), 64'd1);
        if (n >= 4) begin
            d = q1[n-1] - q0[n-1];
            chk("poff_delta_a", 64'(d), 64'h8000);
            d = q1[n-2] - q0[n-2];
            chk("poff_delta_b", 64'(d), 64'h8000);
        end
        chk("ampl_ch0", 64'(ampl[0 +: DW]), 64'hFFF);
        chk("ampl_ch1", 64'(ampl[DW +: DW]), 64'h800);
        chk("ampl_ch2_untouched", 64'(ampl[2*DW +: DW]), 64'h0);
        chk("phase_ch2_untouched", 64'(phase_addr[2*ADW +: ADW]), 64'h0);

        // commit with cfg_data[0]=1
        div_ratio = 7; wait_tick();
        wr(0, 3, 28'd1);
        run(2);
        prev0 = phase_addr[0 +: ADW];
        q0.delete(); q1.delete();
        run(12);
        chk("clr_sample_seen", 64'(q0.size() >= 1), 64'd1);
        if (q0.size() >= 1) begin
`ifdef DDS_PHASE_CLEAR_EN
            chk("clr_ch0_zero", 64'(q0[0]), 64'h0);
            chk("clr_ch1_poff", 64'(q1[0]), 64'h8000);
`else
            d = q0[0] - prev0;
            chk("noclr_ch0_continue", 64'(d), 64'h1000);
`endif
            d = q1[0] - q0[0];
            chk("clr_poff_delta", 64'(d), 64'h8000);
        end

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(99) == 0);
            if ($urandom_range(15) == 0) div_ratio = DVW'($urandom_range(5));
            cfg_valid = 1'($urandom_range(1));
            cfg_ch    = CW'($urandom_range(3));
            cfg_sel   = 2'($urandom_range(3));
            cfg_data  = AW'($urandom);
            step();
        end
        rst = 0; cfg_valid = 0;
        run(5);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
